// File: rtl/egress_packet_fifo.sv
// egress_packet_fifo: store-and-forward packet buffer behind one packet_switch egress port.
// Latency: a packet is presented on m_* the cycle after its tlast beat is stored; 1 beat/cycle each way.
// Backpressure: EGRESS_FIFO_DROP_EN defined -> s_tready high outside reset, overflowing packets dropped;
//               undefined -> s_tready = !full, a packet longer than DEPTH is released cut-through.
//
// Ports:
//   clk, reset           single clock; synchronous active-low reset
//   s_tdata/tvalid/tlast/tready   AXI-Stream ingress from the switch
//   m_tdata/tvalid/tlast/tready   AXI-Stream egress, only complete packets are shown
//   pkt_count            complete packets currently stored
//   drop_count           dropped packets, saturating at 255 (0 when EGRESS_FIFO_DROP_EN is undefined)
// Configuration macro: EGRESS_FIFO_DROP_EN
module egress_packet_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [7:0]            drop_count
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } beat_t;

    beat_t          mem [DEPTH];
    beat_t          rd_beat;
    logic [PW-1:0]  wr_spec;
    logic [PW-1:0]  wr_spec_nxt;
    logic [PW-1:0]  rd_ptr;
    logic           full;
    logic           wr_en;
    logic           commit;
    logic           pkt_inc;
    logic           pkt_dec;
    logic           rd_hs;

    // Occupancy includes the uncommitted tail of the packet being written.
    assign full     = (wr_spec - rd_ptr) == PTR_DEPTH;
    assign rd_beat  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign m_tdata  = rd_beat.dat;
    assign m_tlast  = rd_beat.last;
    assign rd_hs    = m_tvalid && m_tready;
    assign commit   = wr_en && s_tlast;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_spec[ADDR_WIDTH-1:0]] <= '{last: s_tlast, dat: s_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_spec   <= '0;
            rd_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            wr_spec <= wr_spec_nxt;
            if (rd_hs) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Commit and drain in the same cycle cancel out.
            if (pkt_inc && !pkt_dec) begin
                pkt_count <= pkt_count + PTR_ONE;
            end else if (!pkt_inc && pkt_dec) begin
                pkt_count <= pkt_count - PTR_ONE;
            end
        end
    end

`ifdef EGRESS_FIFO_DROP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_t;

    wr_state_t      state;
    wr_state_t      state_nxt;
    logic [PW-1:0]  wr_commit;
    logic           beat_acc;
    logic           rewind;
    logic           drop_inc;

    // Never stalls the switch: overflow is resolved by discarding the packet.
    assign s_tready = reset;
    assign beat_acc = s_tvalid && s_tready;
    assign m_tvalid = pkt_count != '0;
    assign pkt_inc  = commit;
    assign pkt_dec  = rd_hs && m_tlast;

    // A rewind drops every beat of the current packet already written.
    assign wr_spec_nxt = rewind ? wr_commit :
                         wr_en  ? wr_spec + PTR_ONE : wr_spec;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, WRITE: begin
                if (beat_acc) begin
                    if (full) begin
                        state_nxt = s_tlast ? IDLE : DROP;
                    end else begin
                        state_nxt = s_tlast ? IDLE : WRITE;
                    end
                end
            end
            DROP: begin
                if (beat_acc && s_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        rewind   = 1'b0;
        drop_inc = 1'b0;
        if (beat_acc) begin
            case (state)
                IDLE, WRITE: begin
                    if (full) begin
                        rewind   = 1'b1;
                        drop_inc = s_tlast;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
                DROP: begin
                    drop_inc = s_tlast;
                end
                default: begin
                    wr_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_commit  <= '0;
            drop_count <= '0;
        end else begin
            if (commit) begin
                wr_commit <= wr_spec + PTR_ONE;
            end
            if (drop_inc && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`else
    // oversize: the buffer filled with no complete packet, so the head packet
    // is longer than DEPTH and must be streamed out before its tlast arrives.
    // os_wr: ingress is still inside that packet; its tlast is not counted.
    logic oversize;
    logic os_wr;

    assign s_tready    = reset && !full;
    assign wr_en       = s_tvalid && s_tready;
    assign wr_spec_nxt = wr_en ? wr_spec + PTR_ONE : wr_spec;
    assign m_tvalid    = (pkt_count != '0) || (oversize && (rd_ptr != wr_spec));
    assign pkt_inc     = commit && !os_wr;
    assign pkt_dec     = rd_hs && m_tlast && !oversize;
    assign drop_count  = '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            oversize <= 1'b0;
            os_wr    <= 1'b0;
        end else begin
            // While full no beat is accepted, and with pkt_count==0 and no
            // oversize nothing is read, so set and clear never coincide.
            if (full && (pkt_count == '0) && !oversize) begin
                oversize <= 1'b1;
                os_wr    <= 1'b1;
            end else begin
                if (commit && os_wr) begin
                    os_wr <= 1'b0;
                end
                if (rd_hs && m_tlast && oversize) begin
                    oversize <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_egress_packet_fifo.sv
// tb_egress_packet_fifo: directed and random stimulus against a queue-based packet model.
// Latency: model outputs are compared every cycle, #1 after the driving negedge.
// Backpressure: m_tready driven per cycle; ingress holds an offered beat until accepted.
module tb_egress_packet_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [AW:0]   pkt_count;
    logic [7:0]    drop_count;

    always #5 clk = ~clk;

    egress_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } beat_t;

    int     n_chk  = 0;
    int     n_pass = 0;

    // Reference model: beats held in the buffer, in egress order.
    beat_t  q_store[$];
    beat_t  q_part[$];     // drop build: packet being written, not yet committed
    beat_t  got_q[$];      // beats the DUT actually delivered
    int     m_pkts    = 0;
    int     m_drops   = 0;
    bit     m_os      = 0;
    bit     m_os_wr   = 0;
    bit     m_dropping = 0;
    bit     g_acc     = 0;
    bit     g_mr      = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit model_vld();
`ifdef EGRESS_FIFO_DROP_EN
        return m_pkts != 0;
`else
        return (m_pkts != 0) || (m_os && (q_store.size() != 0));
`endif
    endfunction

    task automatic model_clear();
        q_store.delete();
        q_part.delete();
        m_pkts = 0;
        m_drops = 0;
        m_os = 0;
        m_os_wr = 0;
        m_dropping = 0;
    endtask

    // One clock cycle: drive, compare, advance model across the posedge.
    task automatic step(input bit rn, input bit v, input logic [DW-1:0] d, input bit l, input bit mr);
        bit full;
        bit e_srdy;
        bit e_mvld;
        bit rd_last;
        int pk0;
        bit os0;
        bit osw0;
        reset = rn; s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = mr;
        #1;
        full = (q_store.size() + q_part.size()) == DEPTH;
`ifdef EGRESS_FIFO_DROP_EN
        e_srdy = rn;
`else
        e_srdy = rn && !full;
`endif
        e_mvld = model_vld();
        chk("s_tready", int'(s_tready), int'(e_srdy));
        chk("m_tvalid", int'(m_tvalid), int'(e_mvld));
        chk("pkt_count", int'(pkt_count), m_pkts);
        chk("drop_count", int'(drop_count), m_drops);
        if (e_mvld) begin
            chk("m_tdata", int'(m_tdata), int'(q_store[0].dat));
            chk("m_tlast", int'(m_tlast), int'(q_store[0].last));
        end
        g_acc = v && e_srdy;
        pk0 = m_pkts; os0 = m_os; osw0 = m_os_wr;
        if (!rn) begin
            model_clear();
        end else begin
            if (e_mvld && mr) begin
                got_q.push_back('{m_tlast, m_tdata});
                rd_last = q_store[0].last;
                void'(q_store.pop_front());
                if (rd_last) begin
                    if (m_os) m_os = 0;
                    else m_pkts--;
                end
            end
            if (g_acc) begin
`ifdef EGRESS_FIFO_DROP_EN
                if (m_dropping) begin
                    if (l) begin
                        m_dropping = 0;
                        if (m_drops < 255) m_drops++;
                    end
                end else if (full) begin
                    q_part.delete();
                    if (l) begin
                        if (m_drops < 255) m_drops++;
                    end else begin
                        m_dropping = 1;
                    end
                end else begin
                    q_part.push_back('{l, d});
                    if (l) begin
                        foreach (q_part[k]) q_store.push_back(q_part[k]);
                        q_part.delete();
                        m_pkts++;
                    end
                end
`else
                q_store.push_back('{l, d});
                if (l) begin
                    if (osw0) m_os_wr = 0;
                    else m_pkts++;
                end
`endif
            end
`ifndef EGRESS_FIFO_DROP_EN
            if (full && (pk0 == 0) && !os0) begin
                m_os = 1;
                m_os_wr = 1;
            end
`endif
        end
        @(negedge clk);
    endtask

    // Beats [from, to) of a len-beat packet; beat i carries base + inc*i.
    task automatic send_range(input int len, input int from, input int to,
                              input logic [DW-1:0] base, input logic [DW-1:0] inc);
        int i = from;
        int guard = 0;
        logic [DW-1:0] d;
        while (i < to && guard < 2000) begin
            d = base + inc * DW'(i);
            step(1'b1, 1'b1, d, i == len - 1, g_mr);
            if (g_acc) i++;
            guard++;
        end
        chk("send_progress", i, to);
    endtask

    task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic [DW-1:0] inc);
        send_range(len, 0, len, base, inc);
    endtask

    task automatic drain();
        int guard = 0;
        while (model_vld() && guard < 400) begin
            step(1'b1, 1'b0, '0, 1'b0, 1'b1);
            guard++;
        end
        chk("drain_idle", int'(m_tvalid), 0);
    endtask

    initial begin
        int cur_len;
        int cur_i;
        bit offering;
        bit v;
        bit mr;
        bit rn;
        logic [DW-1:0] cur_d;

        reset = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_clear();

        // Reset state, then release.
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_release_srdy", int'(s_tready), 1);

        // Single 4-beat packet with m_tready high.
        g_mr = 1'b1; got_q.delete();
        send_pkt(4, 16'h1111, 16'h1111);
        chk("t1_vld_after_commit", int'(m_tvalid), 1);
        chk("t1_cnt", int'(pkt_count), 1);
        drain();
        chk("t1_beats", got_q.size(), 4);
        for (int k = 0; k < got_q.size(); k++) begin
            chk("t1_dat", int'(got_q[k].dat), 16'h1111 * (k + 1));
            chk("t1_last", int'(got_q[k].last), int'(k == 3));
        end
        chk("t1_cnt0", int'(pkt_count), 0);

        // Three 8-beat packets stored, then drained.
        g_mr = 1'b0; got_q.delete();
        for (int p = 0; p < 3; p++) send_pkt(8, DW'(16'h2000 + 16 * p), 16'h0001);
        chk("t2_cnt3", int'(pkt_count), 3);
        drain();
        chk("t2_beats", got_q.size(), 24);
        for (int k = 0; k < got_q.size(); k++) begin
            chk("t2_dat", int'(got_q[k].dat), 16'h2000 + 16 * (k / 8) + (k % 8));
        end
        chk("t2_cnt0", int'(pkt_count), 0);

`ifdef EGRESS_FIFO_DROP_EN
        // 30-beat packet fills the buffer; 5-beat packet overflows and is dropped.
        g_mr = 1'b0; got_q.delete();
        send_pkt(30, 16'h3000, 16'h0001);
        send_pkt(5, 16'h3100, 16'h0001);
        chk("t3_drop", int'(drop_count), 1);
        chk("t3_cnt", int'(pkt_count), 1);
        chk("t3_srdy", int'(s_tready), 1);
        send_pkt(2, 16'h3200, 16'h0001);
        chk("t3_cnt2", int'(pkt_count), 2);
        drain();
        chk("t3_beats", got_q.size(), 32);
        if (got_q.size() == 32) begin
            chk("t3_small0", int'(got_q[30].dat), 16'h3200);
            chk("t3_small1", int'(got_q[31].dat), 16'h3201);
            chk("t3_small1_last", int'(got_q[31].last), 1);
        end
`else
        // 40-beat packet: stalls at 32 beats, then streams out cut-through.
        g_mr = 1'b0; got_q.delete();
        send_range(40, 0, 32, 16'h4000, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 16'h4020, 1'b0, 1'b0);
            chk("t3_srdy_low", int'(s_tready), 0);
        end
        g_mr = 1'b1;
        send_range(40, 32, 40, 16'h4000, 16'h0001);
        drain();
        chk("t3_beats", got_q.size(), 40);
        for (int k = 0; k < got_q.size(); k++) begin
            chk("t3_dat", int'(got_q[k].dat), 16'h4000 + k);
            chk("t3_last", int'(got_q[k].last), int'(k == 39));
        end
        chk("t3_cnt0", int'(pkt_count), 0);
`endif

        // Reset after 3 beats of a 6-beat packet.
        g_mr = 1'b1; got_q.delete();
        send_range(6, 0, 3, 16'h5000, 16'h0001);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("t4_cnt", int'(pkt_count), 0);
        chk("t4_vld", int'(m_tvalid), 0);
        chk("t4_drop", int'(drop_count), 0);
        send_pkt(6, 16'h5100, 16'h0001);
        drain();
        chk("t4_beats", got_q.size(), 6);
        if (got_q.size() == 6) chk("t4_first", int'(got_q[0].dat), 16'h5100);

        // Commit of B coincides with egress tlast of A.
        g_mr = 1'b0; got_q.delete();
        send_pkt(2, 16'h6000, 16'h0001);
        step(1'b1, 1'b1, 16'h6100, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h6101, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'h6102, 1'b1, 1'b1);
        chk("t5_cnt", int'(pkt_count), 1);
        chk("t5_vld", int'(m_tvalid), 1);
        chk("t5_head", int'(m_tdata), 16'h6100);
        drain();
        chk("t5_beats", got_q.size(), 5);

        // Random traffic, occasional long packets and resets.
        cur_len = 0; cur_i = 0; offering = 0; cur_d = '0;
        for (int c = 0; c < 3000; c++) begin
            if (cur_i >= cur_len) begin
                cur_len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(33, 45))
                                                       : int'($urandom_range(1, 10));
                cur_i = 0;
            end
            if (!offering) cur_d = DW'($urandom);
            v  = offering || ($urandom_range(0, 3) != 0);
            mr = $urandom_range(0, 3) != 0;
            rn = $urandom_range(0, 599) != 0;
            step(rn, v, cur_d, cur_i == cur_len - 1, mr);
            if (!rn) cur_i = cur_len;
            else if (g_acc) cur_i++;
            offering = v && !g_acc && rn;
        end
        s_tvalid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
